// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, widths, FSM
// encoding and the operand bundle latched from a requester.
// Optional build macro: ALU_DIVZERO_GUARD_EN (see alu_share_ctrl).
package alu_ctrl_pkg;

  localparam int unsigned OPW  = 4;
  localparam int unsigned RESW = 8;
  localparam int unsigned SELW = 3;
  localparam int unsigned CNTW = 4;

  localparam logic [SELW-1:0] OP_ADD = 3'd0;
  localparam logic [SELW-1:0] OP_SUB = 3'd1;
  localparam logic [SELW-1:0] OP_AND = 3'd2;
  localparam logic [SELW-1:0] OP_OR  = 3'd3;
  localparam logic [SELW-1:0] OP_XOR = 3'd4;
  localparam logic [SELW-1:0] OP_MUL = 3'd5;
  localparam logic [SELW-1:0] OP_DIV = 3'd6;
  localparam logic [SELW-1:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [SELW-1:0] sel;
  } op_t;

  // True for a divide whose divisor is zero.
  function automatic logic is_divzero(input op_t op);
    return (op.sel == OP_DIV) && (op.b == '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last
// time is granted. Grant is one-hot (or zero) and purely combinational.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // Pick a single winner among the valid ports.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational 4-bit ALU between two requesters. A granted
// request's operands are held on the ALU for SETTLE_CYCLES cycles, then the
// result is captured and offered on a valid/ready response port.
// Optional build macro: ALU_DIVZERO_GUARD_EN -- a divide by zero bypasses
// the ALU and returns result 8'hFF with rsp_err set.
module alu_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_sel,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_zero,
  output logic       rsp_id,
  output logic       rsp_err,
  output logic       busy
);

  import alu_ctrl_pkg::*;

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("alu_share_ctrl: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE_CYCLES - 1);

  state_t          state;
  op_t             op_q;
  logic [CNTW-1:0] cnt;
  logic            last_grant;
  logic [1:0]      grant;
  op_t             req0_op;
  op_t             req1_op;
  op_t             gnt_op;
  logic            gnt_any;
  logic            gnt_id;

  assign req0_op = {req0_a, req0_b, req0_sel};
  assign req1_op = {req1_a, req1_b, req1_sel};

  // Arbitration only in IDLE and never while reset is asserted.
  rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .enable     ((state == ST_IDLE) && rst_n),
    .grant      (grant)
  );

  assign gnt_any    = |grant;
  assign gnt_id     = grant[1];
  assign gnt_op     = grant[1] ? req1_op : req0_op;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign alu_a   = op_q.a;
  assign alu_b   = op_q.b;
  assign alu_sel = op_q.sel;

`ifdef ALU_DIVZERO_GUARD_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Controller FSM: accept, hold operands while the ALU settles, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
`ifdef ALU_DIVZERO_GUARD_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            op_q       <= gnt_op;
            rsp_id     <= gnt_id;
            last_grant <= gnt_id;
            busy       <= 1'b1;
`ifdef ALU_DIVZERO_GUARD_EN
            if (is_divzero(gnt_op)) begin
              rsp_result <= {RESW{1'b1}};
              rsp_carry  <= 1'b0;
              rsp_zero   <= 1'b0;
              err_q      <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= ST_RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= ST_EXEC;
            end
`else
            cnt   <= CNT_INIT;
            state <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            rsp_zero   <= alu_zero;
`ifdef ALU_DIVZERO_GUARD_EN
            err_q      <= 1'b0;
`endif
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU feeds two controller
// instances (settle 1 and settle 4); responses of the settle-1 instance are
// checked against a scoreboard filled at request acceptance.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       id;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_sel, req1_sel;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_carry, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_carry, rsp_zero, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;

  logic       s4_req0_valid, s4_req0_ready, s4_req1_valid, s4_req1_ready;
  logic [3:0] s4_req0_a, s4_req0_b, s4_req1_a, s4_req1_b;
  logic [2:0] s4_req0_sel, s4_req1_sel;
  logic [3:0] s4_alu_a, s4_alu_b;
  logic [2:0] s4_alu_sel;
  logic [7:0] s4_alu_result;
  logic       s4_alu_carry, s4_alu_zero;
  logic       s4_rsp_valid, s4_rsp_ready, s4_rsp_carry, s4_rsp_zero;
  logic       s4_rsp_id, s4_rsp_err, s4_busy;
  logic [7:0] s4_rsp_result;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];
  logic gl[$];
  exp_t mon_e;

  // Reference ALU: {carry, result}.
  function automatic logic [8:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
    logic [8:0] r;
    logic [4:0] s;
    r = '0;
    s = '0;
    case (sel)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r[7:0] = {3'b000, s}; r[8] = s[4]; end
      3'd1: begin r[7:0] = {4'h0, a} - {4'h0, b}; r[8] = (a < b); end
      3'd2: r[7:0] = {4'h0, a & b};
      3'd3: r[7:0] = {4'h0, a | b};
      3'd4: r[7:0] = {4'h0, a ^ b};
      3'd5: r[7:0] = {4'h0, a} * {4'h0, b};
      3'd6: begin
        if (b == 4'h0) r = {1'b1, 8'h00};
        else           r[7:0] = {4'h0, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exp_t expect_of(input logic [3:0] a, input logic [3:0] b,
                                     input logic [2:0] sel, input logic id);
    exp_t       e;
    logic [8:0] r;
`ifdef ALU_DIVZERO_GUARD_EN
    if (sel == 3'd6 && b == 4'h0) return '{result: 8'hFF, carry: 1'b0, zero: 1'b0, id: id, err: 1'b1};
`endif
    r = alu_ref(a, b, sel);
    e.result = r[7:0];
    e.carry  = r[8];
    e.zero   = (r[7:0] == 8'h00);
    e.id     = id;
    e.err    = 1'b0;
    return e;
  endfunction

  always_comb begin
    {alu_carry, alu_result} = alu_ref(alu_a, alu_b, alu_sel);
    alu_zero = (alu_result == 8'h00);
  end

  always_comb begin
    {s4_alu_carry, s4_alu_result} = alu_ref(s4_alu_a, s4_alu_b, s4_alu_sel);
    s4_alu_zero = (s4_alu_result == 8'h00);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_share_ctrl #(.SETTLE_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_zero(rsp_zero), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
  );

  alu_share_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s4_req0_valid), .req0_ready(s4_req0_ready), .req0_a(s4_req0_a), .req0_b(s4_req0_b), .req0_sel(s4_req0_sel),
    .req1_valid(s4_req1_valid), .req1_ready(s4_req1_ready), .req1_a(s4_req1_a), .req1_b(s4_req1_b), .req1_sel(s4_req1_sel),
    .alu_a(s4_alu_a), .alu_b(s4_alu_b), .alu_sel(s4_alu_sel),
    .alu_result(s4_alu_result), .alu_carry(s4_alu_carry), .alu_zero(s4_alu_zero),
    .rsp_valid(s4_rsp_valid), .rsp_ready(s4_rsp_ready), .rsp_result(s4_rsp_result), .rsp_carry(s4_rsp_carry),
    .rsp_zero(s4_rsp_zero), .rsp_id(s4_rsp_id), .rsp_err(s4_rsp_err), .busy(s4_busy)
  );

  // Scoreboard: push on acceptance, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        sb_q.push_back(expect_of(req0_a, req0_b, req0_sel, 1'b0));
        gl.push_back(1'b0);
      end
      if (req1_valid && req1_ready) begin
        sb_q.push_back(expect_of(req1_a, req1_b, req1_sel, 1'b1));
        gl.push_back(1'b1);
      end
      if (rsp_valid && rsp_ready) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected: response result=%h id=%b with nothing outstanding", rsp_result, rsp_id);
        end else begin
          mon_e = sb_q.pop_front();
          if ({rsp_result, rsp_carry, rsp_zero, rsp_id, rsp_err} !== mon_e) begin
            miscompares++;
            $display("FAIL rsp_payload: got result=%h carry=%b zero=%b id=%b err=%b, expected result=%h carry=%b zero=%b id=%b err=%b",
                     rsp_result, rsp_carry, rsp_zero, rsp_id, rsp_err,
                     mon_e.result, mon_e.carry, mon_e.zero, mon_e.id, mon_e.err);
          end
        end
      end
    end
  end

  task automatic wait_accept(input logic port, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (port ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !busy && !rsp_valid) begin
        done = 1'b1;
        break;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL drain: %0d responses still outstanding, busy=%b, expected 0 and busy=0", sb_q.size(), busy);
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic port, input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    bit ok;
    if (port) begin req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1; end
    wait_accept(port, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_port%0d: no ready within budget, expected acceptance", port);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; req0_sel = 3'd0;
    req1_valid = 1'b1; req1_a = 4'h3; req1_b = 4'h4; req1_sel = 3'd0;
    rsp_ready = 1'b0;
    s4_req0_valid = 1'b1; s4_req0_a = 4'h0; s4_req0_b = 4'h0; s4_req0_sel = 3'd0;
    s4_req1_valid = 1'b0; s4_req1_a = 4'h0; s4_req1_b = 4'h0; s4_req1_sel = 3'd0;
    s4_rsp_ready = 1'b0;
    #12;
    vectors++;
    if ({req0_ready, req1_ready, busy, rsp_valid, rsp_err, rsp_id, rsp_carry, rsp_zero} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl: got ready0/ready1/busy/valid/err/id/carry/zero=%b, expected 00000000",
               {req0_ready, req1_ready, busy, rsp_valid, rsp_err, rsp_id, rsp_carry, rsp_zero});
    end
    vectors++;
    if ({rsp_result, alu_a, alu_b, alu_sel} !== 19'h0) begin
      miscompares++;
      $display("FAIL reset_data: got result=%h alu_a=%h alu_b=%h alu_sel=%h, expected all 0", rsp_result, alu_a, alu_b, alu_sel);
    end
    vectors++;
    if ({s4_req0_ready, s4_busy, s4_rsp_valid, s4_rsp_result} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_s4: got ready=%b busy=%b valid=%b result=%h, expected all 0", s4_req0_ready, s4_busy, s4_rsp_valid, s4_rsp_result);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; s4_req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok;
    rsp_ready = 1'b1;
    req0_a = 4'd3; req0_b = 4'd5; req0_sel = 3'b000; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_accept: no ready within budget, expected acceptance"); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({req0_ready, rsp_valid, busy} !== 3'b001) begin
      miscompares++;
      $display("FAIL basic_exec: got ready/valid/busy=%b, expected 001", {req0_ready, rsp_valid, busy});
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_result} !== {1'b1, 8'h08}) begin
      miscompares++;
      $display("FAIL basic_latency: got valid=%b result=%h one edge after exec, expected valid=1 result=08", rsp_valid, rsp_result);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_alternate();
    int start;
    do_reset();
    rsp_ready = 1'b1;
    start = gl.size();
    req0_a = 4'd2; req0_b = 4'd3; req0_sel = 3'b101; req0_valid = 1'b1;
    req1_a = 4'd9; req1_b = 4'd4; req1_sel = 3'b001; req1_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (gl.size() >= start + 4) break;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    vectors++;
    if (gl.size() < start + 4) begin
      miscompares++;
      $display("FAIL alt_count: got %0d grants, expected 4", gl.size() - start);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (gl[start + i] !== 1'(i % 2)) begin
          miscompares++;
          $display("FAIL alt_order: grant %0d went to port %b, expected port %0d", i, gl[start + i], i % 2);
        end
      end
    end
    drain();
  endtask

  task automatic test_backpressure();
    bit         ok;
    logic [11:0] snap;
    rsp_ready = 1'b0;
    req0_a = 4'd1; req0_b = 4'd1; req0_sel = 3'd2; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_accept: no ready within budget, expected acceptance"); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_a = 4'd4; req1_b = 4'd2; req1_sel = 3'd3; req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_valid: rsp_valid never rose, expected 1"); end
    snap = {rsp_result, rsp_carry, rsp_zero, rsp_id, rsp_err};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b1100 ||
          {rsp_result, rsp_carry, rsp_zero, rsp_id, rsp_err} !== snap) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got valid/busy/rdy0/rdy1=%b payload=%h, expected 1100 payload=%h",
                 i, {rsp_valid, busy, req0_ready, req1_ready}, {rsp_result, rsp_carry, rsp_zero, rsp_id, rsp_err}, snap);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, rsp_valid, req1_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL bp_release: got busy/valid/rdy1=%b, expected 001", {busy, rsp_valid, req1_ready});
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    drain();
  endtask

  task automatic test_ops();
    logic       port[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0] av[5]   = '{4'd5, 4'd9, 4'd4, 4'd12, 4'd15};
    logic [3:0] bv[5]   = '{4'd9, 4'd2, 4'd9, 4'd10, 4'd15};
    logic [2:0] sv[5]   = '{3'd7, 3'd6, 3'd1, 3'd4, 3'd0};
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) issue(port[i], av[i], bv[i], sv[i]);
  endtask

  task automatic test_divzero();
    bit ok;
    rsp_ready = 1'b1;
    req0_a = 4'd7; req0_b = 4'd0; req0_sel = 3'b110; req0_valid = 1'b1;
    wait_accept(1'b0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL dz_accept: no ready within budget, expected acceptance"); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
`ifdef ALU_DIVZERO_GUARD_EN
    vectors++;
    if ({rsp_valid, rsp_err, rsp_result} !== {2'b11, 8'hFF}) begin
      miscompares++;
      $display("FAIL dz_latency: got valid=%b err=%b result=%h, expected 1 1 ff", rsp_valid, rsp_err, rsp_result);
    end
`else
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL dz_exec: got valid=%b, expected 0 during settle", rsp_valid);
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL dz_latency: got valid=%b err=%b, expected 1 0", rsp_valid, rsp_err);
    end
`endif
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_settle4();
    bit ok;
    s4_rsp_ready = 1'b0;
    s4_req1_a = 4'd15; s4_req1_b = 4'd15; s4_req1_sel = 3'b101; s4_req1_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s4_req1_ready) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL s4_accept: no ready within budget, expected acceptance"); end
    @(posedge clk); #1;
    s4_req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({s4_rsp_valid, s4_alu_a, s4_alu_b, s4_alu_sel} !== {1'b0, 4'hF, 4'hF, 3'd5}) begin
        miscompares++;
        $display("FAIL s4_settle: cycle %0d got valid=%b alu=%h/%h/%h, expected 0 f/f/5", i, s4_rsp_valid, s4_alu_a, s4_alu_b, s4_alu_sel);
      end
    end
    @(negedge clk);
    vectors++;
    if ({s4_rsp_valid, s4_rsp_result, s4_rsp_carry, s4_rsp_zero, s4_rsp_id, s4_rsp_err} !== {1'b1, 8'hE1, 4'b0010}) begin
      miscompares++;
      $display("FAIL s4_capture: got valid=%b result=%h c/z/id/err=%b, expected 1 e1 0010",
               s4_rsp_valid, s4_rsp_result, {s4_rsp_carry, s4_rsp_zero, s4_rsp_id, s4_rsp_err});
    end
    @(posedge clk); #1;
    s4_rsp_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({s4_rsp_valid, s4_busy, s4_rsp_result} !== {2'b00, 8'hE1}) begin
      miscompares++;
      $display("FAIL s4_done: got valid=%b busy=%b result=%h, expected 0 0 e1", s4_rsp_valid, s4_busy, s4_rsp_result);
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    s4_rsp_ready = 1'b1;
    s4_req0_a = 4'd6; s4_req0_b = 4'd3; s4_req0_sel = 3'd0; s4_req0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (s4_req0_ready) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_accept: no ready within budget, expected acceptance"); end
    @(posedge clk); #1;
    s4_req0_valid = 1'b0;
    @(posedge clk); #2;
    vectors++;
    if ({s4_busy, s4_alu_a} !== {1'b1, 4'd6}) begin
      miscompares++;
      $display("FAIL rst_pre: got busy=%b alu_a=%h, expected 1 6", s4_busy, s4_alu_a);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({s4_busy, s4_rsp_valid, s4_req0_ready, s4_req1_ready, s4_rsp_id, s4_rsp_err,
         s4_alu_a, s4_alu_b, s4_alu_sel, s4_rsp_result} !== 25'h0) begin
      miscompares++;
      $display("FAIL rst_async: got busy=%b valid=%b alu=%h/%h/%h result=%h, expected all 0",
               s4_busy, s4_rsp_valid, s4_alu_a, s4_alu_b, s4_alu_sel, s4_rsp_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    s4_req0_valid = 1'b1; s4_req1_valid = 1'b1;
    s4_req1_a = 4'd1; s4_req1_b = 4'd1; s4_req1_sel = 3'd0;
    #1;
    vectors++;
    if ({s4_req0_ready, s4_req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rst_tie: got ready0/ready1=%b, expected 10", {s4_req0_ready, s4_req1_ready});
    end
    @(posedge clk); #1;
    s4_req0_valid = 1'b0; s4_req1_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!s4_busy && !s4_rsp_valid) begin ok = 1'b1; break; end
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rst_finish: busy=%b valid=%b, expected idle", s4_busy, s4_rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternate();
    test_backpressure();
    test_ops();
    test_divzero();
    test_settle4();
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
